// File: rtl/isqrt_sched_pkg.sv
// Shared types and round-robin pick for the isqrt request scheduler.
package isqrt_sched_pkg;

   localparam int MAX_REQ = 16;

   typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

   // First set bit strictly after ptr, wrapping; unused high bits must be 0
   function automatic req_id_t rr_pick(
      input logic [MAX_REQ-1:0] vld,
      input req_id_t            ptr
   );
      req_id_t g;
      req_id_t idx;
      logic    hit;
      g   = '0;
      hit = 1'b0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         idx = ptr + req_id_t'(k);
         if (!hit && vld[idx]) begin
            g   = idx;
            hit = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/isqrt_rr_scheduler_if.sv
// Requester-side request/response bundle of the isqrt scheduler.
interface isqrt_rr_scheduler_if #(
   parameter int N_REQ = 4
);

   logic [N_REQ-1:0]       req_vld;
   logic [N_REQ-1:0][31:0] req_x;
   logic [N_REQ-1:0]       req_rdy;
   logic [N_REQ-1:0]       rsp_vld;
   logic [15:0]            rsp_y;

   modport master (
      output req_vld, req_x,
      input  req_rdy, rsp_vld, rsp_y
   );

   modport slave (
      input  req_vld, req_x,
      output req_rdy, rsp_vld, rsp_y
   );

endinterface

// File: rtl/isqrt_sched_tag_fifo.sv
// Tag FIFO holding the owner id of every op in flight in the isqrt.
module isqrt_sched_tag_fifo
   import isqrt_sched_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  req_id_t din,
   input  logic    pop,
   output req_id_t dout,
   output logic    empty,
   output logic [AW:0] count
);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        full;
   logic        wr_en;
   logic        rd_en;
   req_id_t     mem [DEPTH];

   // Extra pointer MSB tells full from empty on wrap
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (count == (AW+1)'(DEPTH));
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/isqrt_rr_scheduler.sv
// Round-robin sharing of one pipelined isqrt among N_REQ requesters.
// Define ISQRT_SCHED_STATS_EN to add the stat_issued/stat_hwm ports.
module isqrt_rr_scheduler
   import isqrt_sched_pkg::*;
#(
   parameter  int N_REQ     = 4,
   parameter  int TAG_DEPTH = 16,
   localparam int CW        = $clog2(TAG_DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst,
   isqrt_rr_scheduler_if.slave bus,
   output logic        isqrt_x_vld,
   output logic [31:0] isqrt_x,
   input  logic        isqrt_y_vld,
   input  logic [15:0] isqrt_y,
   output logic        err
`ifdef ISQRT_SCHED_STATS_EN
   ,
   output logic [31:0]   stat_issued,
   output logic [CW-1:0] stat_hwm
`endif
);

   req_id_t          ptr;
   req_id_t          grant;
   req_id_t          head;
   logic [CW-1:0]    count;
   logic             empty;
   logic             can_issue;
   logic             any_vld;
   logic             issue;
   logic             pop;

   assign any_vld   = |bus.req_vld;
   assign grant     = rr_pick(MAX_REQ'(bus.req_vld), ptr);
   // A full FIFO may still accept when a result frees a slot this cycle
   assign can_issue = (count < CW'(TAG_DEPTH)) || isqrt_y_vld;
   assign issue     = |(bus.req_vld & bus.req_rdy);
   assign pop       = !rst && isqrt_y_vld && !empty;

   always_comb begin
      bus.req_rdy = '0;
      if (!rst && any_vld && can_issue)
         bus.req_rdy = N_REQ'(MAX_REQ'(1) << grant);
   end

   always_comb begin
      isqrt_x = 'x;
      for (int i = 0; i < N_REQ; i++)
         if (issue && grant == req_id_t'(i))
            isqrt_x = bus.req_x[i];
   end

   assign isqrt_x_vld = issue;
   assign bus.rsp_y   = isqrt_y_vld ? isqrt_y : 'x;
   assign bus.rsp_vld = pop ? N_REQ'(MAX_REQ'(1) << head) : '0;

   isqrt_sched_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tags (
      .clk   (clk),
      .rst   (rst),
      .push  (issue),
      .din   (grant),
      .pop   (pop),
      .dout  (head),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= req_id_t'(N_REQ - 1);
         err <= 1'b0;
      end else begin
         if (issue) ptr <= grant;
         if (isqrt_y_vld && empty) err <= 1'b1;
      end
   end

`ifdef ISQRT_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued <= '0;
         stat_hwm    <= '0;
      end else begin
         if (issue) stat_issued <= stat_issued + 32'd1;
         if (count > stat_hwm) stat_hwm <= count;
      end
   end
`endif

endmodule

// File: tb/tb_isqrt_rr_scheduler.sv
// Bench: two schedulers (depth 16 and 2) fed identically, each with a
// latency-4 isqrt model, checked against an op-list reference.
module tb_isqrt_rr_scheduler;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force_y = 1'b0;
   logic [N-1:0]       req_vld = '0;
   logic [N-1:0][31:0] req_x   = '0;

   always #5 clk = ~clk;

   isqrt_rr_scheduler_if #(.N_REQ(N)) ia ();
   isqrt_rr_scheduler_if #(.N_REQ(N)) ib ();

   assign ia.req_vld = req_vld;
   assign ia.req_x   = req_x;
   assign ib.req_vld = req_vld;
   assign ib.req_x   = req_x;

   logic [1:0]             xv, yv, er;
   logic [1:0][31:0]       xo;
   logic [1:0][15:0]       yo, orsy;
   logic [1:0][N-1:0]      ordy, orsp;
   logic [1:0][3:0]        pv;
   logic [1:0][3:0][15:0]  py;

   assign ordy[0] = ia.req_rdy;
   assign ordy[1] = ib.req_rdy;
   assign orsp[0] = ia.rsp_vld;
   assign orsp[1] = ib.rsp_vld;
   assign orsy[0] = ia.rsp_y;
   assign orsy[1] = ib.rsp_y;
   assign yv[0]   = pv[0][3] | force_y;
   assign yv[1]   = pv[1][3] | force_y;
   assign yo[0]   = py[0][3];
   assign yo[1]   = py[1][3];

`ifdef ISQRT_SCHED_STATS_EN
   logic [31:0] st_iss0, st_iss1;
   logic [4:0]  st_hwm0;
   logic [1:0]  st_hwm1;
`endif

   isqrt_rr_scheduler #(.N_REQ(N), .TAG_DEPTH(16)) dut0 (
      .clk (clk), .rst (rst), .bus (ia),
      .isqrt_x_vld (xv[0]), .isqrt_x (xo[0]),
      .isqrt_y_vld (yv[0]), .isqrt_y (yo[0]),
      .err (er[0])
`ifdef ISQRT_SCHED_STATS_EN
      , .stat_issued (st_iss0), .stat_hwm (st_hwm0)
`endif
   );

   isqrt_rr_scheduler #(.N_REQ(N), .TAG_DEPTH(2)) dut1 (
      .clk (clk), .rst (rst), .bus (ib),
      .isqrt_x_vld (xv[1]), .isqrt_x (xo[1]),
      .isqrt_y_vld (yv[1]), .isqrt_y (yo[1]),
      .err (er[1])
`ifdef ISQRT_SCHED_STATS_EN
      , .stat_issued (st_iss1), .stat_hwm (st_hwm1)
`endif
   );

   function automatic longint ref_sqrt(input longint x);
      longint r;
      r = longint'($sqrt(real'(x)));
      while (r * r > x) r--;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   // Shared-reset isqrt model, 4-cycle latency
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) pv[d] <= '0;
         else     pv[d] <= {pv[d][2:0], xv[d]};
         py[d][0]   <= xv[d] ? 16'(ref_sqrt(longint'(xo[d]))) : 16'h0;
         py[d][3:1] <= py[d][2:0];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: list of ops in flight per DUT, in issue order
   int          fid [2][64];
   logic [31:0] fx  [2][64];
   int          fh  [2];
   int          ft  [2];
   int          last [2];
   bit          errm [2];
   int          n_iss;
   int          hwm_m;

   function automatic int rr_next(input int lst, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++)
         if (v[(lst + k) % N]) return (lst + k) % N;
      return -1;
   endfunction

   task automatic model_check(input int d, input int dep);
      int    sz;
      int    g;
      bit    can;
      string p;
      p  = (d == 0) ? "d0" : "d1";
      sz = ft[d] - fh[d];
      if (rst) begin
         chk({p, "_rst_rdy"}, 64'(ordy[d]), 0);
         chk({p, "_rst_rsp"}, 64'(orsp[d]), 0);
         chk({p, "_rst_xv"}, 64'(xv[d]), 0);
         fh[d] = 0; ft[d] = 0; last[d] = N - 1; errm[d] = 0;
         if (d == 0) begin n_iss = 0; hwm_m = 0; end
         return;
      end
`ifdef ISQRT_SCHED_STATS_EN
      if (d == 0) begin
         chk("stat_issued", 64'(st_iss0), 64'(n_iss));
         chk("stat_hwm", 64'(st_hwm0), 64'(hwm_m));
         if (sz > hwm_m) hwm_m = sz;
      end
`endif
      can = (sz < dep) || yv[d];
      if (yv[d] && sz > 0) begin
         chk({p, "_rsp_vld"}, 64'(orsp[d]), 64'(1 << fid[d][fh[d] % 64]));
         chk({p, "_rsp_y"}, 64'(orsy[d]),
             64'(ref_sqrt(longint'(fx[d][fh[d] % 64]))));
         fh[d]++;
      end else begin
         chk({p, "_rsp_idle"}, 64'(orsp[d]), 0);
      end
      chk({p, "_err"}, 64'(er[d]), 64'(errm[d]));
      if (yv[d] && sz == 0) errm[d] = 1;
      if (|req_vld && can) begin
         g = rr_next(last[d], req_vld);
         chk({p, "_grant"}, 64'(ordy[d]), 64'(1 << g));
         chk({p, "_xv"}, 64'(xv[d]), 1);
         chk({p, "_x"}, 64'(xo[d]), 64'(req_x[g]));
         fid[d][ft[d] % 64] = g;
         fx[d][ft[d] % 64]  = req_x[g];
         ft[d]++;
         last[d] = g;
         if (d == 0) n_iss++;
      end else begin
         chk({p, "_no_grant"}, 64'(ordy[d]), 0);
         chk({p, "_no_xv"}, 64'(xv[d]), 0);
      end
   endtask

   task automatic tick(input logic r, input logic [N-1:0] v,
                       input logic [N-1:0][31:0] xs, input logic fy);
      @(negedge clk);
      rst = r; req_vld = v; req_x = xs; force_y = fy;
      #1;
      model_check(0, 16);
      model_check(1, 2);
   endtask

   logic [N-1:0][31:0] xs;
   logic [N-1:0][31:0] xz;

   initial begin
      xz = '0;
      tick(1, 0, xz, 0);
      tick(1, 0, xz, 0);

      // Single request, x=144
      xs = '0; xs[0] = 32'd144;
      tick(0, 4'b0001, xs, 0);
      chk("t1_x", 64'(xo[0]), 144);
      chk("t1_rdy", 64'(ordy[0]), 1);
      for (int i = 0; i < 3; i++) tick(0, 0, xz, 0);
      tick(0, 0, xz, 0);
      chk("t1_rsp", 64'(orsp[0]), 1);
      chk("t1_y", 64'(orsy[0]), 12);
      chk("t1_err", 64'(er[0]), 0);

      // All requesting, x_i = i*i
      tick(1, 0, xz, 0);
      for (int i = 0; i < N; i++) xs[i] = 32'(i * i);
      for (int j = 0; j < 8; j++) begin
         tick(0, 4'hF, xs, 0);
         chk("t2_grant", 64'(ordy[0]), 64'(1 << (j % 4)));
         if (j >= 4) begin
            chk("t2_rsp", 64'(orsp[0]), 64'(1 << (j % 4)));
            chk("t2_y", 64'(orsy[0]), 64'(j % 4));
         end
      end
      for (int i = 0; i < 6; i++) tick(0, 0, xz, 0);

      // Depth-2 instance stalls after two issues
      for (int j = 0; j < 6; j++) begin
         for (int i = 0; i < N; i++) xs[i] = $urandom;
         tick(0, 4'hF, xs, 0);
         if (j == 2 || j == 3)
            chk("t3_stall", 64'(ordy[1]), 0);
         else
            chk("t3_rdy", 64'(ordy[1] != 0), 1);
         if (j == 4) chk("t3_rsp", 64'(orsp[1] != 0), 1);
      end
      for (int i = 0; i < 8; i++) tick(0, 0, xz, 0);

      // Random traffic
      for (int j = 0; j < 300; j++) begin
         for (int i = 0; i < N; i++) xs[i] = $urandom;
         tick(0, 4'($urandom), xs, 0);
      end
      for (int i = 0; i < 8; i++) tick(0, 0, xz, 0);

      // Result with nothing in flight
      tick(0, 0, xz, 1);
      chk("t4_rsp", 64'(orsp[0]), 0);
      tick(0, 0, xz, 0);
      chk("t4_err0", 64'(er[0]), 1);
      chk("t4_err1", 64'(er[1]), 1);
      for (int i = 0; i < 3; i++) tick(0, 0, xz, 0);
      chk("t4_err_hold", 64'(er[0]), 1);

      // Reset with ops in flight
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < N; i++) xs[i] = $urandom;
         tick(0, 4'b0001, xs, 0);
      end
      tick(1, 4'hF, xs, 0);
      chk("t5_rdy", 64'(ordy[0]), 0);
      chk("t5_rsp", 64'(orsp[0]), 0);
      tick(0, 4'hF, xs, 0);
      chk("t5_first", 64'(ordy[0]), 1);
      chk("t5_err", 64'(er[0]), 0);
      for (int i = 0; i < 8; i++) tick(0, 0, xz, 0);

`ifdef ISQRT_SCHED_STATS_EN
      tick(1, 0, xz, 0);
      for (int rep = 0; rep < 4; rep++) begin
         for (int j = 0; j < ((rep < 3) ? 3 : 1); j++) begin
            for (int i = 0; i < N; i++) xs[i] = $urandom;
            tick(0, 4'b0001, xs, 0);
         end
         for (int i = 0; i < 5; i++) tick(0, 0, xz, 0);
      end
      chk("t6_issued", 64'(st_iss0), 10);
      chk("t6_hwm", 64'(st_hwm0), 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
